// File: rtl/demux_serial_feeder.sv
// Parallel-to-serial feeder driving the i/s inputs of a downstream 1x2 demux.
// Bit order: LSB first by default; define DEMUX_FEED_MSB_FIRST_EN for MSB first.
module demux_serial_feeder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic [WIDTH-1:0] sel_in,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             hold,
    output logic             i,
    output logic             s,
    output logic             out_valid,
    output logic             done
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] sel_q, sel_d;
    logic [CW-1:0]    count_q, count_d;
    logic             last_bit, accept, head_d, head_s;
    logic [WIDTH-1:0] data_sh, sel_sh;

    always_comb begin
`ifdef DEMUX_FEED_MSB_FIRST_EN
        head_d  = data_q[WIDTH-1];
        head_s  = sel_q[WIDTH-1];
        data_sh = {data_q[WIDTH-2:0], 1'b0};
        sel_sh  = {sel_q[WIDTH-2:0], 1'b0};
`else
        head_d  = data_q[0];
        head_s  = sel_q[0];
        data_sh = {1'b0, data_q[WIDTH-1:1]};
        sel_sh  = {1'b0, sel_q[WIDTH-1:1]};
`endif
    end

    // A new word can be taken on the edge that retires the last bit, so
    // back-to-back words leave no bubble.
    always_comb begin
        last_bit  = (state_q == SHIFT) && (count_q == CW'(1));
        in_ready  = (state_q == IDLE) || (last_bit && !hold);
        accept    = in_valid && in_ready;
        out_valid = (state_q == SHIFT);
        i         = out_valid && head_d;
        s         = out_valid && head_s;
        done      = last_bit && !hold;
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        sel_d   = sel_q;
        count_d = count_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SHIFT;
                    data_d  = data_in;
                    sel_d   = sel_in;
                    count_d = CW'(WIDTH);
                end
            end
            SHIFT: begin
                if (!hold) begin
                    if (accept) begin
                        data_d  = data_in;
                        sel_d   = sel_in;
                        count_d = CW'(WIDTH);
                    end else if (count_q > CW'(1)) begin
                        data_d  = data_sh;
                        sel_d   = sel_sh;
                        count_d = count_q - CW'(1);
                    end else begin
                        state_d = IDLE;
                        data_d  = '0;
                        sel_d   = '0;
                        count_d = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            sel_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
            count_q <= count_d;
        end
    end
endmodule

// File: tb/tb_demux_serial_feeder.sv
// Self-checking bench for demux_serial_feeder: directed cases plus random
// traffic compared against a queue-of-pending-bits reference model.
module tb_demux_serial_feeder;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] data_in = '0;
    logic [W-1:0] sel_in = '0;
    logic         in_valid = 1'b0;
    logic         hold = 1'b0;
    logic         in_ready, i, s, out_valid, done;

    int errors = 0;
    int checks = 0;

    // Each entry is one bit still owed to the demux: {data, sel, last}.
    logic [2:0] q[$];
    logic obs_ov, obs_rdy, obs_i, obs_s, obs_done;

    demux_serial_feeder #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .sel_in(sel_in),
        .in_valid(in_valid), .in_ready(in_ready), .hold(hold),
        .i(i), .s(s), .out_valid(out_valid), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic push_word(input logic [W-1:0] d, input logic [W-1:0] sl);
        int idx;
        for (int k = 0; k < W; k++) begin
`ifdef DEMUX_FEED_MSB_FIRST_EN
            idx = W - 1 - k;
`else
            idx = k;
`endif
            q.push_back({d[idx], sl[idx], (k == W - 1)});
        end
    endtask

    // One clock cycle: drive, check against model, clock, update model.
    task automatic cyc(input logic v, input logic [W-1:0] d, input logic [W-1:0] sl, input logic h);
        logic [2:0] hd;
        logic       er;
        logic [4:0] ex;
        in_valid = v; data_in = d; sel_in = sl; hold = h;
        #1;
        hd = (q.size() != 0) ? q[0] : 3'b000;
        er = (q.size() == 0) || (q.size() == 1 && !h);
        ex = {q.size() != 0, hd[2], hd[1], hd[0] && !h, er};
        chk("cycle{ov,i,s,done,rdy}", {27'd0, out_valid, i, s, done, in_ready}, {27'd0, ex});
        obs_ov = out_valid; obs_rdy = in_ready; obs_i = i; obs_s = s; obs_done = done;
        @(posedge clk);
        #1;
        if (q.size() != 0 && !h) void'(q.pop_front());
        if (v && er) push_word(d, sl);
    endtask

    initial begin
        logic [W-1:0] seq_i, seq_s, seq_done;
        int ov_cnt, rdy_cnt;

        // Reset values while rst is high
        #1;
        chk("reset_outputs", {27'd0, out_valid, i, s, done, in_ready}, 32'h1);
        @(posedge clk); #1;
        rst = 1'b0;

        // Reset mid-word discards the word
        cyc(1'b1, 8'hFF, 8'hFF, 1'b0);
        for (int k = 0; k < 3; k++) cyc(1'b0, 8'h00, 8'h00, 1'b0);
        rst = 1'b1;
        #1;
        chk("reset_midword", {27'd0, out_valid, i, s, done, in_ready}, 32'h1);
        q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 4; k++) cyc(1'b0, 8'h00, 8'h00, 1'b0);

        // Basic word with explicit sequences
        cyc(1'b1, 8'hA5, 8'h0F, 1'b0);
        for (int k = 0; k < W; k++) begin
            cyc(1'b0, 8'h00, 8'h00, 1'b0);
            seq_i[k] = obs_i; seq_s[k] = obs_s; seq_done[k] = obs_done;
        end
        chk("basic_i_seq", {24'd0, seq_i}, 32'hA5);
`ifdef DEMUX_FEED_MSB_FIRST_EN
        chk("basic_s_seq", {24'd0, seq_s}, 32'hF0);
`else
        chk("basic_s_seq", {24'd0, seq_s}, 32'h0F);
`endif
        chk("basic_done_seq", {24'd0, seq_done}, 32'h80);

        // Back-to-back words with in_valid held high
        ov_cnt = 0; rdy_cnt = 0;
        cyc(1'b1, 8'h3C, 8'hAA, 1'b0);
        for (int k = 0; k < W; k++) begin
            cyc(1'b1, 8'hC3, 8'h55, 1'b0);
            ov_cnt += int'(obs_ov); rdy_cnt += int'(obs_rdy);
        end
        for (int k = 0; k < W; k++) begin
            cyc(1'b0, 8'h00, 8'h00, 1'b0);
            ov_cnt += int'(obs_ov);
        end
        chk("b2b_ov_cycles", ov_cnt, 16);
        chk("b2b_ready_cycles", rdy_cnt, 1);
        cyc(1'b0, 8'h00, 8'h00, 1'b0);

        // Hold on bit 2 for 3 cycles, and hold on the last bit
        cyc(1'b1, 8'hA5, 8'h0F, 1'b0);
        cyc(1'b0, 8'h00, 8'h00, 1'b0);
        cyc(1'b0, 8'h00, 8'h00, 1'b0);
        for (int k = 0; k < 3; k++) cyc(1'b0, 8'h00, 8'h00, 1'b1);
        for (int k = 0; k < 5; k++) cyc(1'b0, 8'h00, 8'h00, 1'b0);
        cyc(1'b1, 8'h12, 8'h34, 1'b1);
        chk("hold_last_not_ready", {31'd0, obs_rdy}, 32'h0);
        cyc(1'b0, 8'h00, 8'h00, 1'b0);
        cyc(1'b0, 8'h00, 8'h00, 1'b0);

        // Ignored input while busy
        cyc(1'b1, 8'h5A, 8'hC3, 1'b0);
        for (int k = 0; k < 4; k++) cyc(1'b0, 8'h00, 8'h00, 1'b0);
        for (int k = 0; k < 6; k++) cyc(1'b1, 8'hFF, 8'hFF, 1'b0);
        for (int k = 0; k < W + 2; k++) cyc(1'b0, 8'h00, 8'h00, 1'b0);

        // Random traffic
        for (int n = 0; n < 600; n++)
            cyc(1'($urandom_range(0, 1)), W'($urandom), W'($urandom),
                $urandom_range(0, 3) == 0);
        for (int k = 0; k < 3 * W; k++) cyc(1'b0, 8'h00, 8'h00, 1'b0);
        chk("drained", {31'd0, out_valid}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/demux_serial_feeder.md
# demux_serial_feeder

Parallel-to-serial feeder that drives the `i`/`s` inputs of the 1x2 demultiplexer stage directly downstream of it.
- Accepts a WIDTH-bit data word and a WIDTH-bit route word through a valid/ready handshake.
- Emits one data bit on `i` and its route bit on `s` per clock, so each data bit is steered to `y[0]` or `y[1]` of the demux.
- Supports downstream hold (stall) and back-to-back words with no bubble.

## Interface
- WIDTH, 8, bits per word; legal range 2..32.

- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- data_in  input  WIDTH  word to serialise.
- sel_in  input  WIDTH  per-bit route; bit k = 0 routes data bit k to `y[0]`, bit k = 1 routes it to `y[1]`.
- in_valid  input  1  `data_in`/`sel_in` valid.
- in_ready  output  1  feeder can accept a word this cycle.
- hold  input  1  freeze serial output for this cycle.
- i  output  1  serial data bit to the demux.
- s  output  1  serial select bit to the demux.
- out_valid  output  1  `i`/`s` carry a live bit.
- done  output  1  high while the last bit of a word is presented and `hold` = 0.

## Operation
- State machine has two states, IDLE and SHIFT. Registers: data shift reg, sel shift reg, bit counter ($clog2(WIDTH+1) bits).
- Accept condition: `in_valid && in_ready` at a rising edge.
- `in_ready` = (state == IDLE) || (state == SHIFT && count == 1 && !hold). It is combinational from state, count and `hold`.
- IDLE:
  - `out_valid`=0, `i`=0, `s`=0, `done`=0.
  - On accept: load both shift regs, set count=WIDTH, go to SHIFT.
- SHIFT:
  - `out_valid`=1.
  - `i`/`s` = current head bit of the data/sel shift regs (combinational from the regs).
  - `hold`=1: regs, count and outputs frozen; `done`=0.
  - `hold`=0 and count>1: shift by one and decrement count.
  - `hold`=0 and count==1: `done`=1. If accept occurs at this edge, reload and stay in SHIFT (count=WIDTH); otherwise go to IDLE.
- `hold` in IDLE has no effect.
- `in_valid` while `in_ready`=0 is ignored; the upstream keeps its word until accepted.
- `data_in`/`sel_in` are sampled only at accept; later changes do not affect a word in flight.
- Reset mid-word: the word is discarded. There is no partial output after reset release.

## Timing
- Reset values:
  - state=IDLE, shift regs=0, count=0.
  - `i`=0, `s`=0, `out_valid`=0, `done`=0, `in_ready`=1 (after reset and while `rst` is high).
- Latency: word accepted at edge N → bit 0 on `i`/`s` in the cycle following edge N.
- Without hold, bit k is presented in cycle N+1+k; the last bit is presented in cycle N+WIDTH with `done`=1.
- Throughput: one word per WIDTH cycles with `in_valid` held high (no idle cycle between words).
- Each `hold` cycle extends the current bit by exactly one cycle.
- The demux is combinational, so `y` follows `i`/`s` in the same cycle.

## Configuration
- Macro DEMUX_FEED_MSB_FIRST_EN selects bit order; it applies to data and sel identically.
- Defined: bits are emitted MSB first (bit WIDTH-1 first, then WIDTH-2, …).
- Undefined (default): bits are emitted LSB first (bit 0 first).

## Test plan
- Reset check: assert `rst` mid-SHIFT of word 8'hFF/8'hFF → same cycle `out_valid`=0, `i`=0, `s`=0, `in_ready`=1; after release, no stray bits.
- Basic word: `data_in`=8'hA5, `sel_in`=8'h0F, no hold, LSB first.
  - `i` sequence 1,0,1,0,0,1,0,1; `s` sequence 1,1,1,1,0,0,0,0.
  - `done` high only on the 8th bit; demux `y[1]` gets bits 0–3 and `y[0]` gets bits 4–7.
- Back-to-back: `in_valid` held high with 8'h3C/8'hAA then 8'hC3/8'h55.
  - 16 consecutive `out_valid` cycles; `in_ready`=1 only in the cycle of the 8th bit of word 1.
- Hold: `hold`=1 for 3 cycles while bit 2 of 8'hA5 is presented → bit 2 shown for 4 cycles; `done` delayed by 3 cycles; `in_ready` low during hold on the last bit.
- Ignored input: `in_valid`=1 with 8'hFF while busy on bit 4 → current word is unaffected and the new word is not captured until `in_ready`.
- MSB order: with DEMUX_FEED_MSB_FIRST_EN defined, 8'hA5/8'h0F → `i` sequence 1,0,1,0,0,1,0,1; `s` sequence 0,0,0,0,1,1,1,1.
